// File: rtl/conv3x3_engine.sv
// 3x3 signed-kernel convolution with shift or /9 normalise and saturation; CONV_ABS_OUT_EN selects |x| instead of clamp-to-0.
// Latency 3 cycles (multiply, sum, normalise/saturate), 1 window/cycle.
// Backpressure: whole pipeline stalls while the output holds an unaccepted result.
module conv3x3_engine #(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [9*DATA_W-1:0]   i_pixel_data,
  input  logic                  i_pixel_valid,
  output logic                  o_pixel_ready,
  input  logic                  i_coef_we,
  input  logic [3:0]            i_coef_addr,
  input  logic [COEF_W-1:0]     i_coef_data,
  input  logic                  i_norm_sel,
  input  logic [SHIFT_W-1:0]    i_shift,
  output logic [DATA_W-1:0]     o_result_pixel,
  output logic                  o_result_valid,
  input  logic                  i_result_ready
);

  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SUM_W  = DATA_W + COEF_W + 5;
  localparam logic signed [SUM_W-1:0] NINE = SUM_W'(9);
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 << DATA_W) - 1);

  logic adv;
  assign adv           = !o_result_valid | i_result_ready;
  assign o_pixel_ready = adv;

  logic signed [COEF_W-1:0] coef [9];

  // Products are registered from the current kernel, so a same-cycle write is seen only by later windows.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 9; k++) coef[k] <= COEF_W'(1);
    end else if (i_coef_we && i_coef_addr <= 4'd8) begin
      coef[i_coef_addr] <= i_coef_data;
    end
  end

  logic signed [PROD_W-1:0] prod_c [9];
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_c[k] = $signed({{(PROD_W-DATA_W){1'b0}}, i_pixel_data[k*DATA_W +: DATA_W]})
                * $signed({{(PROD_W-COEF_W){coef[k][COEF_W-1]}}, coef[k]});
    end
  end

  logic signed [PROD_W-1:0] s1_prod [9];
  logic                     s1_vld, s1_sel;
  logic [SHIFT_W-1:0]       s1_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld <= 1'b0;
    end else if (adv) begin
      s1_vld   <= i_pixel_valid;
      s1_prod  <= prod_c;
      s1_sel   <= i_norm_sel;
      s1_shift <= i_shift;
    end
  end

  logic signed [SUM_W-1:0] sum_c;
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < 9; k++) begin
      sum_c = sum_c + {{(SUM_W-PROD_W){s1_prod[k][PROD_W-1]}}, s1_prod[k]};
    end
  end

  logic signed [SUM_W-1:0] s2_sum;
  logic                    s2_vld, s2_sel;
  logic [SHIFT_W-1:0]      s2_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_vld <= 1'b0;
    end else if (adv) begin
      s2_vld   <= s1_vld;
      s2_sum   <= sum_c;
      s2_sel   <= s1_sel;
      s2_shift <= s1_shift;
    end
  end

  logic signed [SUM_W-1:0] norm_c, mag_c;
  logic [DATA_W-1:0]       pix_c;

  // Signed division truncates toward zero, matching the /9 rounding rule.
  always_comb begin
    if (s2_sel) norm_c = s2_sum / NINE;
    else        norm_c = s2_sum >>> s2_shift;
    mag_c = norm_c;
    if (norm_c < 0) begin
`ifdef CONV_ABS_OUT_EN
      mag_c = -norm_c;
`else
      mag_c = '0;
`endif
    end
    if (mag_c > MAXV) pix_c = '1;
    else              pix_c = mag_c[DATA_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result_valid <= 1'b0;
      o_result_pixel <= '0;
    end else if (adv) begin
      o_result_valid <= s2_vld;
      if (s2_vld) o_result_pixel <= pix_c;
    end
  end

endmodule
